// File: rtl/tetris_pkg.sv
// tetris_pkg
//   Shared definitions for the collision checker: playfield defaults,
//   coordinate widths, FSM state encoding and the cell coordinate helper.
//   No ports (package).
package tetris_pkg;

    localparam int COLS_DEF  = 10;
    localparam int ROWS_DEF  = 20;
    localparam int COL_W_DEF = 4;
    localparam int ROW_W_DEF = 5;

    localparam int X_W   = 5;   // signed anchor column width
    localparam int Y_W   = 6;   // signed anchor row width
    localparam int OFF_W = 2;   // unsigned per-cell offset width
    localparam int CW    = 7;   // signed working width for cx/cy

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } tcc_state_e;

    // Anchor is already sign-extended; the offset is zero-extended so that
    // 2'b11 means +3, never -1.
    function automatic logic signed [CW-1:0] cell_coord(
        input logic signed [CW-1:0] anchor,
        input logic [OFF_W-1:0]     off
    );
        return anchor + $signed({{(CW-OFF_W){1'b0}}, off});
    endfunction

endpackage

// File: rtl/tetris_cell_bounds.sv
// tetris_cell_bounds
//   Combinational classifier for one absolute cell coordinate.
//   Ports:
//     cx, cy     in   signed cell column / row
//     oob        out  left of column 0, right of COLS-1, or below ROWS-1
//     above_top  out  in the hidden rows above the board (cy<0) but horizontally legal
module tetris_cell_bounds
    import tetris_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic signed [CW-1:0] cx,
    input  logic signed [CW-1:0] cy,
    output logic                 oob,
    output logic                 above_top
);

    localparam logic signed [CW-1:0] COLS_S = CW'(COLS);
    localparam logic signed [CW-1:0] ROWS_S = CW'(ROWS);

    always_comb begin
        oob       = cx[CW-1] || (cx >= COLS_S) || (cy >= ROWS_S);
        above_top = cy[CW-1] && !oob;
    end

endmodule

// File: rtl/tetris_collision_checker.sv
// tetris_collision_checker
//   Checks whether a four-cell piece placed at (piece_x, piece_y) overlaps the
//   playfield walls/floor or any occupied cell, reading the board RAM one
//   cell at a time.
//   Optional build macro: COLLIDE_HIT_MASK_EN -- adds hit_mask output and
//   evaluates all four cells instead of stopping at the first hit.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     start               request, accepted only while busy=0
//     piece_x, piece_y    signed anchor
//     dx0..dx3, dy0..dy3  unsigned cell offsets
//     rd_en/rd_row/rd_col board read strobe and address
//     rd_data             occupancy, valid the cycle after rd_en
//     busy, done          evaluation in progress / one-cycle completion pulse
//     collide             result, held until the next accepted start
//     hit_mask            per-cell hit bits (macro builds only)
//   Handshake: start is a single-cycle request sampled on posedge; it is taken
//   only when busy=0 (IDLE or the DONE cycle) and dropped otherwise. done pulses
//   once per accepted start; collide/hit_mask are stable from done onward.
module tetris_collision_checker
    import tetris_pkg::*;
#(
    parameter int COLS  = COLS_DEF,
    parameter int ROWS  = ROWS_DEF,
    parameter int COL_W = COL_W_DEF,
    parameter int ROW_W = ROW_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [X_W-1:0]   piece_x,
    input  logic [Y_W-1:0]   piece_y,
    input  logic [OFF_W-1:0] dx0,
    input  logic [OFF_W-1:0] dx1,
    input  logic [OFF_W-1:0] dx2,
    input  logic [OFF_W-1:0] dx3,
    input  logic [OFF_W-1:0] dy0,
    input  logic [OFF_W-1:0] dy1,
    input  logic [OFF_W-1:0] dy2,
    input  logic [OFF_W-1:0] dy3,
    output logic             rd_en,
    output logic [ROW_W-1:0] rd_row,
    output logic [COL_W-1:0] rd_col,
    input  logic             rd_data,
    output logic             busy,
    output logic             done,
    output logic             collide
`ifdef COLLIDE_HIT_MASK_EN
    ,
    output logic [3:0]       hit_mask
`endif
);

`ifdef COLLIDE_HIT_MASK_EN
    localparam bit EARLY_EXIT = 1'b0;
`else
    localparam bit EARLY_EXIT = 1'b1;
`endif

    tcc_state_e             state_q, state_d;
    logic [1:0]             idx_q;
    logic                   idx_inc;
    logic signed [CW-1:0]   px_q, py_q;
    logic [3:0][OFF_W-1:0]  dx_q, dy_q;
    logic [3:0]             mask_q;

    logic                   start_ok;
    logic signed [CW-1:0]   cx, cy;
    logic                   oob, above_top;
    logic                   eval_read;
    logic                   hit_now;

    // Current cell: the 2-bit index muxes the latched offsets.
    assign cx = cell_coord(px_q, dx_q[idx_q]);
    assign cy = cell_coord(py_q, dy_q[idx_q]);

    tetris_cell_bounds #(.COLS(COLS), .ROWS(ROWS)) u_bounds (
        .cx        (cx),
        .cy        (cy),
        .oob       (oob),
        .above_top (above_top)
    );

    assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign eval_read = !oob && !above_top;
    assign hit_now   = ((state_q == ST_EVAL) && oob) ||
                       ((state_q == ST_WAIT) && rd_data);

    // State register and latched datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            px_q    <= '0;
            py_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                idx_q  <= 2'd0;
                px_q   <= {{(CW-X_W){piece_x[X_W-1]}}, piece_x};
                py_q   <= {{(CW-Y_W){piece_y[Y_W-1]}}, piece_y};
                dx_q   <= {dx3, dx2, dx1, dx0};
                dy_q   <= {dy3, dy2, dy1, dy0};
                mask_q <= '0;
            end else begin
                if (hit_now)
                    mask_q[idx_q] <= 1'b1;
                if (idx_inc)
                    idx_q <= idx_q + 2'd1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        idx_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok)
                    state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (eval_read) begin
                    state_d = ST_WAIT;
                end else if ((oob && EARLY_EXIT) || (idx_q == 2'd3)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_EVAL;
                    idx_inc = 1'b1;
                end
            end
            ST_WAIT: begin
                if ((rd_data && EARLY_EXIT) || (idx_q == 2'd3)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_EVAL;
                    idx_inc = 1'b1;
                end
            end
            ST_DONE: begin
                // A start in the done cycle is legal since busy is already low.
                state_d = start_ok ? ST_EVAL : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs. Address is forced to zero whenever no read is issued.
    always_comb begin
        rd_en  = (state_q == ST_EVAL) && eval_read;
        rd_row = '0;
        rd_col = '0;
        if (rd_en) begin
            rd_row = cy[ROW_W-1:0];
            rd_col = cx[COL_W-1:0];
        end
        busy    = (state_q == ST_EVAL) || (state_q == ST_WAIT);
        done    = (state_q == ST_DONE);
        collide = |mask_q;
    end

`ifdef COLLIDE_HIT_MASK_EN
    assign hit_mask = mask_q;
`endif

endmodule
